// File: rtl/burst_decoder_pkg.sv
// Shared types, defaults and the majority-vote helper for the burst decoder.
package burst_decoder_pkg;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  localparam int unsigned SYM_LEN_DEF = 3;
  localparam int unsigned WORD_W_DEF  = 8;

  // A symbol decodes to 1 when strictly more than half of its samples are 1.
  function automatic logic maj_vote(input int unsigned ones, input int unsigned len);
    return (2 * ones) > len;
  endfunction

endpackage

// File: rtl/burst_sym_sampler.sv
// Registers the serial burst input, frames it into SYM_LEN-cycle symbols and
// majority-votes each one into a decoded bit with a strobe and a disagreement flag.
module burst_sym_sampler
  import burst_decoder_pkg::*;
#(
  parameter int unsigned SYM_LEN = SYM_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b_i,
  output logic bit_o,
  output logic bit_stb_o,
  output logic sym_err_o
);

  localparam int unsigned CntW = $clog2(SYM_LEN + 1);
  localparam logic [CntW-1:0] LastPhase = CntW'(SYM_LEN - 1);
  localparam logic [CntW-1:0] FullOnes  = CntW'(SYM_LEN);

  logic            b_q;
  logic            vld_q;
  logic [CntW-1:0] phase_q, phase_d;
  logic [CntW-1:0] ones_q, ones_d;
  logic [CntW-1:0] ones_cur;
  logic            sym_close;
  logic            sym_err_q, sym_err_d;

  // vld_q marks that b_q holds a real sample, so phase 0 lines up with the first edge after reset.
  always_comb begin
    ones_cur  = ones_q + CntW'(b_q);
    sym_close = vld_q && (phase_q == LastPhase);
    phase_d   = phase_q;
    ones_d    = ones_q;
    if (vld_q) begin
      phase_d = sym_close ? '0 : phase_q + CntW'(1);
      ones_d  = sym_close ? '0 : ones_cur;
    end
    sym_err_d = sym_close && (ones_cur != '0) && (ones_cur != FullOnes);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q       <= 1'b0;
      vld_q     <= 1'b0;
      phase_q   <= '0;
      ones_q    <= '0;
      sym_err_q <= 1'b0;
    end else begin
      b_q       <= b_i;
      vld_q     <= 1'b1;
      phase_q   <= phase_d;
      ones_q    <= ones_d;
      sym_err_q <= sym_err_d;
    end
  end

  assign bit_o     = maj_vote(32'(ones_cur), SYM_LEN);
  assign bit_stb_o = sym_close;
  assign sym_err_o = sym_err_q;

endmodule

// File: rtl/burst_decoder.sv
// Decodes the upstream burst stream into WORD_W-bit words (MSB first) on a valid/ready port.
// Optional trailing even-parity symbol and parity_err output with BURST_DECODER_PARITY_EN.
module burst_decoder
  import burst_decoder_pkg::*;
#(
  parameter int unsigned SYM_LEN = SYM_LEN_DEF,
  parameter int unsigned WORD_W  = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              b_in,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              sym_err,
`ifdef BURST_DECODER_PARITY_EN
  output logic              parity_err,
`endif
  output logic              overflow
);

`ifdef BURST_DECODER_PARITY_EN
  localparam int unsigned WordLen = WORD_W + 1;
`else
  localparam int unsigned WordLen = WORD_W;
`endif
  localparam int unsigned CntW = $clog2(WORD_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WordLen - 1);

  logic bit_val;
  logic bit_stb;

  burst_sym_sampler #(
    .SYM_LEN(SYM_LEN)
  ) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .b_i      (b_in),
    .bit_o    (bit_val),
    .bit_stb_o(bit_stb),
    .sym_err_o(sym_err)
  );

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              word_done;
  logic [WORD_W-1:0] new_word;
  logic [WORD_W-1:0] word_q, word_d;
  out_state_t        state_q, state_d;
  logic              overflow_q, overflow_d;
  logic              load;

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    word_done = 1'b0;
    if (bit_stb) begin
      shift_d   = WORD_W'({shift_q, bit_val});
      word_done = (bit_cnt_q == LastCnt);
      bit_cnt_d = word_done ? '0 : bit_cnt_q + CntW'(1);
    end
  end

`ifdef BURST_DECODER_PARITY_EN
  // The closing symbol is the parity bit, so the data bits are already in shift_q.
  logic perr_q, perr_d, new_perr;
  assign new_word = shift_q;
  assign new_perr = ^{shift_q, bit_val};
`else
  assign new_word = shift_d;
`endif

  always_comb begin
    state_d    = state_q;
    overflow_d = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      OUT_EMPTY: begin
        if (word_done) begin
          load    = 1'b1;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (word_done) begin
          if (word_ready) load = 1'b1;
          else            overflow_d = 1'b1;
        end else if (word_ready) begin
          state_d = OUT_EMPTY;
        end
      end
    endcase
    word_d = load ? new_word : word_q;
`ifdef BURST_DECODER_PARITY_EN
    perr_d = load ? new_perr : perr_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      word_q     <= '0;
      state_q    <= OUT_EMPTY;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      word_q     <= word_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef BURST_DECODER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end
  assign parity_err = perr_q;
`endif

  assign word_data  = word_q;
  assign word_valid = (state_q == OUT_FULL);
  assign overflow   = overflow_q;

endmodule
